// File: rtl/nc_sched_pkg.sv
// Shared types and constants for the nc_sched bit-serial AND/parity scheduler.
package nc_sched_pkg;

    localparam int unsigned NC_SCHED_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

endpackage

// File: rtl/nc_logic_cell.sv
// Single-bit AND/XOR cell shared by both requesters of nc_sched_1.
module nc_logic_cell (
    input  logic x,
    input  logic y,
    output logic xy_and,
    output logic xy_xor
);

    assign xy_and = x & y;
    assign xy_xor = x ^ y;

endmodule

// File: rtl/nc_sched_1.sv
// Two-requester round-robin scheduler around one shared bit-serial AND/XOR cell.
// Optional synchronous flush port enabled by defining NC_SCHED_FLUSH_EN.
module nc_sched_1
    import nc_sched_pkg::*;
#(
    parameter int W = NC_SCHED_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef NC_SCHED_FLUSH_EN
    input  logic         flush,
`endif
    input  logic         req0_valid,
    input  logic         req1_valid,
    output logic         req0_ready,
    output logic         req1_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_and,
    output logic         rsp_xor
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

`ifndef NC_SCHED_FLUSH_EN
    logic flush;
    assign flush = 1'b0;
`endif

    state_t        state;
    state_t        state_nxt;
    logic          prio;
    logic          grant;
    logic          accept;
    logic          last_bit;
    logic          id_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  acc_and;
    logic          acc_xor;
    logic [CW-1:0] cnt;
    logic          cell_and;
    logic          cell_xor;

    always_comb begin
        grant = prio;
        if (req0_valid && !req1_valid)
            grant = 1'b0;
        else if (!req0_valid && req1_valid)
            grant = 1'b1;
    end

    assign req0_ready = (state == IDLE) && !flush && !grant && req0_valid;
    assign req1_ready = (state == IDLE) && !flush &&  grant && req1_valid;
    assign accept     = req0_ready || req1_ready;
    assign last_bit   = (cnt == CW'(W - 1));

    nc_logic_cell u_cell (
        .x      (a_q[cnt]),
        .y      (b_q[cnt]),
        .xy_and (cell_and),
        .xy_xor (cell_xor)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (accept)    state_nxt = BUSY;
                BUSY:    if (last_bit)  state_nxt = DONE;
                DONE:    if (rsp_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // cnt holds at W-1 on the last bit so it never wraps within an operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= 1'b0;
            cnt     <= '0;
            acc_and <= '0;
            acc_xor <= 1'b0;
            prio    <= 1'b0;
        end else begin
            if (accept) begin
                a_q     <= grant ? req1_a : req0_a;
                b_q     <= grant ? req1_b : req0_b;
                id_q    <= grant;
                cnt     <= '0;
                acc_and <= '0;
                acc_xor <= 1'b0;
            end else if (state == BUSY && !flush) begin
                acc_and[cnt] <= cell_and;
                acc_xor      <= acc_xor ^ cell_xor;
                if (!last_bit)
                    cnt <= cnt + 1'b1;
            end
            if (state == DONE && rsp_ready && !flush)
                prio <= ~id_q;
        end
    end

    assign rsp_valid = (state == DONE);
    assign rsp_id    = rsp_valid && id_q;
    assign rsp_and   = rsp_valid ? acc_and : '0;
    assign rsp_xor   = rsp_valid && acc_xor;

endmodule

// File: tb/tb_nc_sched_1.sv
// Self-checking bench for nc_sched_1: transaction-level model plus directed scenarios.
// Flush scenario and random flush pulses are built only when NC_SCHED_FLUSH_EN is defined.
module tb_nc_sched_1;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         req0_valid = 1'b0;
    logic         req1_valid = 1'b0;
    logic         req0_ready;
    logic         req1_ready;
    logic [W-1:0] req0_a = '0;
    logic [W-1:0] req0_b = '0;
    logic [W-1:0] req1_a = '0;
    logic [W-1:0] req1_b = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic         rsp_id;
    logic [W-1:0] rsp_and;
    logic         rsp_xor;
`ifdef NC_SCHED_FLUSH_EN
    logic         flush = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    nc_sched_1 #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef NC_SCHED_FLUSH_EN
        .flush      (flush),
`endif
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_and    (rsp_and),
        .rsp_xor    (rsp_xor)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit fl();
`ifdef NC_SCHED_FLUSH_EN
        return flush;
`else
        return 1'b0;
`endif
    endfunction

    // Transaction-level model: an operation occupies the block for W cycles,
    // then its precomputed result is offered until taken.
    bit           m_in_op = 1'b0;
    int           m_left  = 0;
    bit           m_id    = 1'b0;
    bit           m_prio  = 1'b0;
    bit           m_xor   = 1'b0;
    logic [W-1:0] m_and   = '0;

    function automatic bit m_grant();
        if (req0_valid != req1_valid)
            return req1_valid;
        return m_prio;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_in_op <= 1'b0;
            m_left  <= 0;
            m_prio  <= 1'b0;
        end else if (fl()) begin
            m_in_op <= 1'b0;
        end else if (!m_in_op) begin
            if (req0_valid || req1_valid) begin
                m_in_op <= 1'b1;
                m_left  <= W;
                m_id    <= m_grant();
                m_and   <= m_grant() ? (req1_a & req1_b) : (req0_a & req0_b);
                m_xor   <= m_grant() ? ^(req1_a ^ req1_b) : ^(req0_a ^ req0_b);
            end
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
        end else if (rsp_ready) begin
            m_in_op <= 1'b0;
            m_prio  <= !m_id;
        end
    end

    always @(negedge clk) begin
        bit idle;
        bit res;
        idle = !m_in_op;
        res  = m_in_op && (m_left == 0);
        chk("req0_ready", 32'(req0_ready), 32'(idle && !fl() && req0_valid && !m_grant()));
        chk("req1_ready", 32'(req1_ready), 32'(idle && !fl() && req1_valid && m_grant()));
        chk("rsp_valid",  32'(rsp_valid),  32'(res));
        chk("rsp_id",     32'(rsp_id),     32'(res && m_id));
        chk("rsp_and",    32'(rsp_and),    res ? 32'(m_and) : 32'd0);
        chk("rsp_xor",    32'(rsp_xor),    32'(res && m_xor));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_ready(input bit n, output int c);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (n ? req1_ready : req0_ready) begin
                c = cyc;
                return;
            end
        end
        c = 0;
        checks++;
        errors++;
        $display("FAIL wait_ready%0d: got no ready expected ready within 100 cycles", n);
    endtask

    task automatic wait_rsp(output int c, output logic id, output logic [W-1:0] a, output logic x);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                c  = cyc;
                id = rsp_id;
                a  = rsp_and;
                x  = rsp_xor;
                step();
                return;
            end
        end
        c = 0; id = 1'b0; a = '0; x = 1'b0;
        checks++;
        errors++;
        $display("FAIL wait_rsp: got no rsp_valid expected one within 100 cycles");
    endtask

    initial begin
        int           t0, t1;
        logic         id, x;
        logic [W-1:0] a;

        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_and", 32'(rsp_and), 32'd0);
        step();
        rst_n = 1'b1;

        // single request, latency W+1 from accept to first rsp_valid
        rsp_ready = 1'b1;
        req0_a = 8'hF0; req0_b = 8'hCD; req0_valid = 1'b1;
        wait_ready(1'b0, t0);
        step();
        req0_valid = 1'b0;
        wait_rsp(t1, id, a, x);
        chk("single_latency", 32'(t1 - t0), 32'(W + 1));
        chk("single_id", 32'(id), 32'd0);
        chk("single_and", 32'(a), 32'hC0);
        chk("single_xor", 32'(x), 32'd1);

        // simultaneous requests after reset
        do_reset();
        req0_a = 8'hFF; req0_b = 8'h0F; req1_a = 8'hAA; req1_b = 8'h55;
        req0_valid = 1'b1; req1_valid = 1'b1;
        wait_ready(1'b0, t0);
        step();
        req0_valid = 1'b0;
        wait_rsp(t1, id, a, x);
        chk("simul_first_id", 32'(id), 32'd0);
        chk("simul_first_and", 32'(a), 32'h0F);
        chk("simul_first_xor", 32'(x), 32'd0);
        wait_ready(1'b1, t0);
        step();
        req1_valid = 1'b0;
        wait_rsp(t1, id, a, x);
        chk("simul_second_id", 32'(id), 32'd1);
        chk("simul_second_and", 32'(a), 32'h00);
        chk("simul_second_xor", 32'(x), 32'd0);

        // back-to-back fairness
        do_reset();
        req0_a = 8'h3A; req0_b = 8'h6C; req1_a = 8'h91; req1_b = 8'hE7;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_rsp(t1, id, a, x);
            chk("fair_id", 32'(id), 32'(i % 2));
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // backpressure in DONE
        rsp_ready = 1'b0;
        req0_a = 8'h3C; req0_b = 8'h5A; req0_valid = 1'b1;
        req1_a = 8'h12; req1_b = 8'h34;
        wait_ready(1'b0, t0);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        wait_rsp(t1, id, a, x);
        chk("bp_id", 32'(id), 32'd0);
        chk("bp_and", 32'(a), 32'h18);
        chk("bp_xor", 32'(x), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
            chk("bp_hold_id", 32'(rsp_id), 32'(id));
            chk("bp_hold_and", 32'(rsp_and), 32'(a));
            chk("bp_hold_xor", 32'(rsp_xor), 32'(x));
            chk("bp_hold_ready", 32'({req0_ready, req1_ready}), 32'd0);
        end
        step();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_idle_valid", 32'(rsp_valid), 32'd0);
        chk("bp_idle_ready1", 32'(req1_ready), 32'd1);
        step();
        req1_valid = 1'b0;
        wait_rsp(t1, id, a, x);
        chk("bp_next_id", 32'(id), 32'd1);
        chk("bp_next_and", 32'(a), 32'h10);
        chk("bp_next_xor", 32'(x), 32'd1);

        // reset mid-BUSY, after a req0 completion has moved the pointer to requester 1
        req0_a = 8'h0F; req0_b = 8'hFF; req0_valid = 1'b1;
        wait_ready(1'b0, t0);
        step();
        req0_valid = 1'b0;
        wait_rsp(t1, id, a, x);
        req1_a = 8'h77; req1_b = 8'h0F; req1_valid = 1'b1;
        wait_ready(1'b1, t0);
        step();
        req1_valid = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        chk("rstmid_valid", 32'(rsp_valid), 32'd0);
        chk("rstmid_id", 32'(rsp_id), 32'd0);
        chk("rstmid_and", 32'(rsp_and), 32'd0);
        chk("rstmid_xor", 32'(rsp_xor), 32'd0);
        chk("rstmid_ready", 32'({req0_ready, req1_ready}), 32'd0);
        step();
        rst_n = 1'b1;
        req0_a = 8'h81; req0_b = 8'hC3; req0_valid = 1'b1; req1_valid = 1'b1;
        wait_ready(1'b0, t0);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp(t1, id, a, x);
        chk("rstmid_next_id", 32'(id), 32'd0);
        chk("rstmid_next_and", 32'(a), 32'h81);
        chk("rstmid_next_xor", 32'(x), 32'd0);

`ifdef NC_SCHED_FLUSH_EN
        // flush mid-BUSY drops req0's operation; pending req1 served next
        do_reset();
        req0_a = 8'h5A; req0_b = 8'hFF; req1_a = 8'hC3; req1_b = 8'h96;
        req0_valid = 1'b1; req1_valid = 1'b1;
        wait_ready(1'b0, t0);
        step();
        req0_valid = 1'b0;
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_rsp(t1, id, a, x);
        req1_valid = 1'b0;
        chk("flush_next_id", 32'(id), 32'd1);
        chk("flush_next_and", 32'(a), 32'h82);
        chk("flush_next_xor", 32'(x), 32'd0);
`endif

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            req0_a = W'($urandom); req0_b = W'($urandom);
            req1_a = W'($urandom); req1_b = W'($urandom);
            rsp_ready = ($urandom_range(0, 2) != 0);
`ifdef NC_SCHED_FLUSH_EN
            flush = ($urandom_range(0, 39) == 0);
`endif
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
`ifdef NC_SCHED_FLUSH_EN
        flush = 1'b0;
`endif
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
